// File: rtl/dsm_stereo_mod_pkg.sv
// Shared constants for the stereo sigma-delta modulator: FSM encoding, dither LFSR
// parameters and the full-scale / saturation-limit helpers.
package dsm_stereo_mod_pkg;

    typedef enum logic {
        ST_MUTE = 1'b0,
        ST_RUN  = 1'b1
    } dsm_state_e;

    // Fibonacci taps 16,14,13,11 map to bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

    function automatic longint fs_value(input int data_w);
        return longint'(1) << (data_w - 1);
    endfunction

    function automatic longint sat_max(input int acc_w);
        return (longint'(1) << (acc_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int acc_w);
        return -(longint'(1) << (acc_w - 1));
    endfunction

endpackage

// File: rtl/dsm_stereo_mod_channel_2nd.sv
// One channel of the 2nd-order 1-bit modulator: two saturating integrators and the
// registered output bit that also selects the +/-FS feedback.
module dsm_channel_2nd
    import dsm_stereo_mod_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ACC_W  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              step,
    input  logic [DATA_W:0]   x,
    output logic              y,
    output logic              ovf
);

    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] FS_S   = SW'(fs_value(DATA_W));
    localparam logic signed [SW-1:0] LIM_HI = SW'(sat_max(ACC_W));
    localparam logic signed [SW-1:0] LIM_LO = SW'(sat_min(ACC_W));

    logic [ACC_W-1:0] r_i1;
    logic [ACC_W-1:0] r_i2;
    logic             r_y;

    logic signed [SW-1:0] w_fb;
    logic signed [SW-1:0] w_x_ext;
    logic signed [SW-1:0] w_i1_ext;
    logic signed [SW-1:0] w_i2_ext;
    logic signed [SW-1:0] w_i1n_ext;
    logic signed [SW-1:0] w_sum1;
    logic signed [SW-1:0] w_sum2;
    logic [ACC_W-1:0]     w_i1n;
    logic [ACC_W-1:0]     w_i2n;
    logic                 w_clip1;
    logic                 w_clip2;

    assign w_x_ext  = {{(SW-DATA_W-1){x[DATA_W]}}, x};
    assign w_i1_ext = {{2{r_i1[ACC_W-1]}}, r_i1};
    assign w_i2_ext = {{2{r_i2[ACC_W-1]}}, r_i2};

    // Sums run two bits wider than the integrators so clamping sees the true value.
    always_comb begin
        w_fb    = r_y ? FS_S : -FS_S;
        w_sum1  = w_i1_ext + w_x_ext - w_fb;
        w_clip1 = 1'b0;
        w_i1n   = w_sum1[ACC_W-1:0];
        if (w_sum1 > LIM_HI) begin
            w_i1n   = LIM_HI[ACC_W-1:0];
            w_clip1 = 1'b1;
        end else if (w_sum1 < LIM_LO) begin
            w_i1n   = LIM_LO[ACC_W-1:0];
            w_clip1 = 1'b1;
        end

        w_i1n_ext = {{2{w_i1n[ACC_W-1]}}, w_i1n};
        w_sum2    = w_i2_ext + w_i1n_ext - w_fb;
        w_clip2   = 1'b0;
        w_i2n     = w_sum2[ACC_W-1:0];
        if (w_sum2 > LIM_HI) begin
            w_i2n   = LIM_HI[ACC_W-1:0];
            w_clip2 = 1'b1;
        end else if (w_sum2 < LIM_LO) begin
            w_i2n   = LIM_LO[ACC_W-1:0];
            w_clip2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_y  <= 1'b0;
        end else if (step) begin
            r_i1 <= w_i1n;
            r_i2 <= w_i2n;
            r_y  <= ~w_i2n[ACC_W-1];
        end
    end

    assign y   = r_y;
    assign ovf = step & ~clr & (w_clip1 | w_clip2);

endmodule

// File: rtl/dsm_stereo_mod.sv
// Stereo 2nd-order sigma-delta modulator with input latches, MUTE/RUN control, timeout
// and idle pattern. Define DSM_DITHER_EN to add +/-1 LSB LFSR dither to each channel.
module dsm_stereo_mod
    import dsm_stereo_mod_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int DATA_W  = 24,
    parameter int ACC_W   = 28,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] data_l_i,
    input  logic            data_l_stb_i,
    input  logic [IN_W-1:0] data_r_i,
    input  logic            data_r_stb_i,
    input  logic            mod_stb_i,
    output logic [1:0]      dsm_out_o,
    output logic            dsm_valid_o,
    output logic            overload_o,
    output logic            dbg_state_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Handshake: every *_stb_i is a one-cycle valid pulse with no ready; the block
    // accepts a strobe on any cycle, back-to-back strobes included.

    dsm_state_e       r_state;
    dsm_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic             r_seen_l;
    logic             r_seen_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_p;
    logic             r_overload;

    logic             w_any_stb;
    logic             w_timeout;
    logic             w_step;
    logic             w_clr;
    logic [DATA_W:0]  w_x_l;
    logic [DATA_W:0]  w_x_r;
    logic             w_y_l;
    logic             w_y_r;
    logic             w_ovf_l;
    logic             w_ovf_r;
    logic             w_unused_lsbs;

    assign w_unused_lsbs = ^{data_l_i[IN_W-DATA_W-1:0], data_r_i[IN_W-DATA_W-1:0]};
    assign w_any_stb     = data_l_stb_i | data_r_stb_i;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_MUTE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_MUTE: begin
                if (r_seen_l && r_seen_r) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (mod_stb_i && !w_any_stb && (r_cnt == CNT_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_MUTE;
                end
            end
            default: w_state_nxt = ST_MUTE;
        endcase
    end

    assign w_step = (r_state == ST_RUN) & mod_stb_i & ~w_timeout;
    assign w_clr  = (r_state == ST_MUTE) | w_timeout;

    // Latches run in either state; a step in the strobe cycle still uses the old hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_seen_l <= 1'b0;
            r_seen_r <= 1'b0;
        end else begin
            if (data_l_stb_i) begin
                r_hold_l <= data_l_i[IN_W-1 -: DATA_W];
                r_seen_l <= 1'b1;
            end else if (w_timeout) begin
                r_seen_l <= 1'b0;
            end
            if (data_r_stb_i) begin
                r_hold_r <= data_r_i[IN_W-1 -: DATA_W];
                r_seen_r <= 1'b1;
            end else if (w_timeout) begin
                r_seen_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != ST_RUN) r_cnt <= '0;
        else if (w_any_stb)           r_cnt <= '0;
        else if (mod_stb_i)           r_cnt <= w_timeout ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || w_timeout)                        r_p <= 1'b0;
        else if (r_state == ST_MUTE && mod_stb_i)    r_p <= ~r_p;
    end

    always_ff @(posedge clk) begin
        if (rst) r_overload <= 1'b0;
        else     r_overload <= w_ovf_l | w_ovf_r;
    end

`ifdef DSM_DITHER_EN
    localparam logic [DATA_W:0] DITH_P1 = (DATA_W+1)'(1);
    localparam logic [DATA_W:0] DITH_M1 = '1;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst || r_state == ST_MUTE || w_timeout) r_lfsr <= LFSR_SEED;
        else if (w_step)                             r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
    end

    assign w_x_l = {r_hold_l[DATA_W-1], r_hold_l} + (r_lfsr[0] ? DITH_P1 : DITH_M1);
    assign w_x_r = {r_hold_r[DATA_W-1], r_hold_r} + (r_lfsr[7] ? DITH_P1 : DITH_M1);
`else
    assign w_x_l = {r_hold_l[DATA_W-1], r_hold_l};
    assign w_x_r = {r_hold_r[DATA_W-1], r_hold_r};
`endif

    dsm_channel_2nd #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_ch_l (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .step (w_step),
        .x    (w_x_l),
        .y    (w_y_l),
        .ovf  (w_ovf_l)
    );

    dsm_channel_2nd #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_ch_r (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .step (w_step),
        .x    (w_x_r),
        .y    (w_y_r),
        .ovf  (w_ovf_r)
    );

    // MUTE shows the idle toggle on both pins; it is cleared together with y on timeout.
    assign dsm_out_o   = (r_state == ST_RUN) ? {w_y_r, w_y_l} : {r_p, r_p};
    assign dsm_valid_o = (r_state == ST_RUN);
    assign overload_o  = r_overload;
    assign dbg_state_o = r_state;

endmodule
